// File: rtl/block_quant.sv
// JPEG luminance quantizer for DCT row packets: reciprocal multiply (S1), round-and-shift (S2).
// Stall-all valid/ready pipeline. The row index is pck_no mod 8 and the column index is the lane number.
module block_quant #(
    parameter int unsigned total_width = 280,
    parameter int unsigned x_size      = 4,
    parameter int unsigned y_size      = 4,
    parameter int unsigned pck_num     = 16,
    parameter int unsigned data_width  = 256,
    parameter int unsigned frac_bits   = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [total_width-1:0] i_data,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [total_width-1:0] o_data,
    output logic                   o_valid,
    input  logic                   i_ready
);

    localparam int unsigned lanes  = 8;
    localparam int unsigned lane_w = 32;
    localparam int unsigned rom_w  = 16;
    localparam int unsigned prod_w = lane_w + rom_w + 1;
    localparam int unsigned hdr_w  = total_width - data_width;

    localparam logic signed [prod_w-1:0] rnd = prod_w'(1) << (frac_bits - 1);

    // round(65536 / Q) for the Annex K luminance table, indexed [row][column]
    localparam logic [rom_w-1:0] recip_rom [8][8] = '{
        '{16'd4096, 16'd5958, 16'd6554, 16'd4096, 16'd2731, 16'd1638, 16'd1285, 16'd1074},
        '{16'd5461, 16'd5461, 16'd4681, 16'd3449, 16'd2521, 16'd1130, 16'd1092, 16'd1192},
        '{16'd4681, 16'd5041, 16'd4096, 16'd2731, 16'd1638, 16'd1150, 16'd950,  16'd1170},
        '{16'd4681, 16'd3855, 16'd2979, 16'd2260, 16'd1285, 16'd753,  16'd819,  16'd1057},
        '{16'd3641, 16'd2979, 16'd1771, 16'd1170, 16'd964,  16'd601,  16'd636,  16'd851},
        '{16'd2731, 16'd1872, 16'd1192, 16'd1024, 16'd809,  16'd630,  16'd580,  16'd712},
        '{16'd1337, 16'd1024, 16'd840,  16'd753,  16'd636,  16'd542,  16'd546,  16'd649},
        '{16'd910,  16'd712,  16'd690,  16'd669,  16'd585,  16'd655,  16'd636,  16'd662}
    };

    logic                     advance;
    logic [2:0]               row;
    logic signed [prod_w-1:0] prod [lanes];

    logic                     s1_valid;
    logic [hdr_w-1:0]         s1_hdr;
    logic signed [prod_w-1:0] s1_prod [lanes];

    // Stage advance and per-lane products of the incoming row
    always_comb begin
        advance = ~o_valid | i_ready;
        o_ready = advance;
        row     = i_data[x_size+y_size +: 3];
        for (int k = 0; k < lanes; k++) begin
            prod[k] = prod_w'($signed(i_data[total_width-1-lane_w*k -: lane_w]))
                    * $signed(prod_w'(recip_rom[row][k]));
        end
    end

    // Both stages move together; any downstream stall freezes the whole pipe
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_hdr   <= '0;
            for (int k = 0; k < lanes; k++) begin
                s1_prod[k] <= '0;
            end
            o_valid  <= 1'b0;
            o_data   <= '0;
        end else if (advance) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_hdr <= i_data[hdr_w-1:0];
                for (int k = 0; k < lanes; k++) begin
                    s1_prod[k] <= prod[k];
                end
            end
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_data[hdr_w-1:0] <= s1_hdr;
                for (int k = 0; k < lanes; k++) begin
                    o_data[total_width-1-lane_w*k -: lane_w] <=
                        lane_w'((s1_prod[k] + rnd) >>> frac_bits);
                end
            end
        end
    end

endmodule
